// File: rtl/bmp_write_sequencer.sv
// Frame sequencer in front of the BMP writer. It takes a valid/ready RGB pixel stream, tags
// each pixel with raster coordinates and emits a registered write strobe one cycle later.
module bmp_write_sequencer #(
    parameter int MAX_WIDTH  = 768,
    parameter int MAX_HEIGHT = 512,
    parameter int CW         = 11
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   cfg_width,
    input  logic [31:0]   cfg_height,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_r,
    input  logic [7:0]    s_g,
    input  logic [7:0]    s_b,
    output logic          wr_en,
    output logic [CW-1:0] wr_row,
    output logic [CW-1:0] wr_col,
    output logic [7:0]    wr_r,
    output logic [7:0]    wr_g,
    output logic [7:0]    wr_b,
    output logic [31:0]   width_o,
    output logic [31:0]   height_o,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] row_d;
    logic [CW-1:0] col_d;
    logic          s_ready_q;
    logic          busy_q;
    logic          wr_en_q;
    logic          frame_done_q;
    logic          cfg_err_q;
    logic [CW-1:0] wr_row_q;
    logic [CW-1:0] wr_col_q;
    logic [7:0]    wr_r_q;
    logic [7:0]    wr_g_q;
    logic [7:0]    wr_b_q;
    logic [31:0]   width_q;
    logic [31:0]   height_q;

    logic          geom_ok;
    logic [CW-1:0] col_last;
    logic [CW-1:0] row_last;
    logic          at_col_end;
    logic          at_row_end;

    // Geometry is range-checked here, so truncating width-1/height-1 to CW bits is safe later.
    assign geom_ok = (cfg_width  >= 32'd1) && (cfg_width  <= 32'(MAX_WIDTH)) &&
                     (cfg_height >= 32'd1) && (cfg_height <= 32'(MAX_HEIGHT));

    assign col_last   = CW'(width_q  - 32'd1);
    assign row_last   = CW'(height_q - 32'd1);
    assign at_col_end = (col_q == col_last);
    assign at_row_end = (row_q == row_last);

    assign col_d = at_col_end ? '0 : col_q + CW'(1);
    assign row_d = at_col_end ? row_q + CW'(1) : row_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_r_q       <= '0;
            wr_g_q       <= '0;
            wr_b_q       <= '0;
            width_q      <= '0;
            height_q     <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (geom_ok) begin
                            width_q   <= cfg_width;
                            height_q  <= cfg_height;
                            row_q     <= '0;
                            col_q     <= '0;
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (start) begin
                        cfg_err_q <= 1'b1;
                    end
                    // Abort wins over a pixel offered in the same cycle.
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b0;
                    end else if (s_valid) begin
                        wr_en_q  <= 1'b1;
                        wr_row_q <= row_q;
                        wr_col_q <= col_q;
                        wr_r_q   <= s_r;
                        wr_g_q   <= s_g;
                        wr_b_q   <= s_b;
                        col_q    <= col_d;
                        row_q    <= row_d;
                        if (at_col_end && at_row_end) begin
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                            s_ready_q    <= 1'b0;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        cfg_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    s_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign wr_r       = wr_r_q;
    assign wr_g       = wr_g_q;
    assign wr_b       = wr_b_q;
    assign width_o    = width_q;
    assign height_o   = height_q;

endmodule

// File: tb/tb_bmp_write_sequencer.sv
// Scoreboard bench for bmp_write_sequencer: stimulus pushes expected writes, a negedge
// monitor pops and compares them whenever wr_en is seen.
module tb_bmp_write_sequencer;

    localparam int CW = 11;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   cfg_width = '0;
    logic [31:0]   cfg_height = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_r = '0;
    logic [7:0]    s_g = '0;
    logic [7:0]    s_b = '0;
    logic          wr_en;
    logic [CW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [7:0]    wr_r;
    logic [7:0]    wr_g;
    logic [7:0]    wr_b;
    logic [31:0]   width_o;
    logic [31:0]   height_o;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    bmp_write_sequencer #(.MAX_WIDTH(768), .MAX_HEIGHT(512), .CW(CW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .width_o(width_o), .height_o(height_o), .busy(busy),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic [7:0]    r;
        logic [7:0]    g;
        logic [7:0]    b;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pix(input int tid, input int i);
        return 8'(tid * 32 + i);
    endfunction

    // Monitor: every write strobe must match the oldest expected pixel.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (wr_en) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got row=%0d col=%0d with no pending pixel", wr_row, wr_col);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({wr_row, wr_col, wr_r, wr_g, wr_b, frame_done} !==
                        {e.row, e.col, e.r, e.g, e.b, e.last}) begin
                        errors++;
                        $display("FAIL wr_pixel: got row=%0d col=%0d rgb=%h%h%h done=%b expected row=%0d col=%0d rgb=%h%h%h done=%b",
                                 wr_row, wr_col, wr_r, wr_g, wr_b, frame_done,
                                 e.row, e.col, e.r, e.g, e.b, e.last);
                    end else begin
                        $display("wr row=%0d col=%0d rgb=%h%h%h done=%b", wr_row, wr_col, wr_r, wr_g, wr_b, frame_done);
                    end
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: got frame_done=1 with wr_en=0 expected wr_en=1");
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Returns one cycle after the start edge, with cfg_err/busy already updated.
    task automatic do_start(input int w, input int h);
        start = 1'b1;
        cfg_width = 32'(w);
        cfg_height = 32'(h);
        @(posedge HCLK); #1;
        start = 1'b0;
    endtask

    // Offers pixels idx0..idx0+n-1 of a w x h frame; gap inserts an idle cycle between pixels;
    // mid >= 0 raises a second start alongside that pixel.
    task automatic send(input int tid, input int w, input int h, input int idx0, input int n,
                        input bit gap, input int mid);
        for (int i = idx0; i < idx0 + n; i++) begin
            exp_t e;
            s_valid = 1'b1;
            s_r = pix(tid, i);
            s_g = ~pix(tid, i);
            s_b = pix(tid, i) ^ 8'h5A;
            e.row = CW'(i / w);
            e.col = CW'(i % w);
            e.r = s_r;
            e.g = s_g;
            e.b = s_b;
            e.last = (i == w * h - 1);
            exp_q.push_back(e);
            if (i == mid) begin
                start = 1'b1;
                cfg_width = 32'd4;
                cfg_height = 32'd4;
            end
            @(posedge HCLK); #1;
            if (i == mid) begin
                start = 1'b0;
                chk("mid_start_cfg_err", 64'(cfg_err), 64'd1);
            end
            s_valid = 1'b0;
            if (gap && i != idx0 + n - 1) begin
                @(posedge HCLK); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int dn0;

        #3;
        chk("reset_wr_en", 64'(wr_en), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_width", 64'(width_o), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cycles(1);
        chk("idle_s_ready", 64'(s_ready), 64'd0);

        // Test 1: 4x2 frame, valid held high
        wr0 = wr_cnt; dn0 = done_cnt;
        do_start(4, 2);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_width", 64'(width_o), 64'd4);
        chk("t1_height", 64'(height_o), 64'd2);
        send(1, 4, 2, 0, 8, 1'b0, -1);
        chk("t1_busy_done", 64'(busy), 64'd0);
        cycles(2);
        chk("t1_wr_count", 64'(wr_cnt - wr0), 64'd8);
        chk("t1_done_count", 64'(done_cnt - dn0), 64'd1);

        // Test 2: 3x1 frame with valid toggling 1,0,1,0,1
        wr0 = wr_cnt; dn0 = done_cnt;
        do_start(3, 1);
        send(2, 3, 1, 0, 3, 1'b1, -1);
        cycles(2);
        chk("t2_wr_count", 64'(wr_cnt - wr0), 64'd3);
        chk("t2_done_count", 64'(done_cnt - dn0), 64'd1);

        // Test 3: rejected geometries, then the largest legal one
        do_start(0, 2);
        chk("t3_w0_cfg_err", 64'(cfg_err), 64'd1);
        chk("t3_w0_busy", 64'(busy), 64'd0);
        do_start(769, 2);
        chk("t3_w769_cfg_err", 64'(cfg_err), 64'd1);
        chk("t3_w769_width", 64'(width_o), 64'd3);
        do_start(4, 513);
        chk("t3_h513_cfg_err", 64'(cfg_err), 64'd1);
        chk("t3_h513_busy", 64'(busy), 64'd0);
        do_start(768, 512);
        chk("t3_max_cfg_err", 64'(cfg_err), 64'd0);
        chk("t3_max_busy", 64'(busy), 64'd1);
        chk("t3_max_width", 64'(width_o), 64'd768);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("t3_abort_busy", 64'(busy), 64'd0);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        chk("t3_idle_abort_width", 64'(width_o), 64'd768);

        // Test 4: abort after 5 of 8 pixels, then a fresh 2x2 frame
        wr0 = wr_cnt; dn0 = done_cnt;
        do_start(4, 2);
        send(4, 4, 2, 0, 5, 1'b0, -1);
        abort = 1'b1;
        s_valid = 1'b1;
        s_r = 8'hEE;
        cycles(1);
        abort = 1'b0;
        s_valid = 1'b0;
        chk("t4_abort_s_ready", 64'(s_ready), 64'd0);
        chk("t4_abort_busy", 64'(busy), 64'd0);
        cycles(3);
        chk("t4_abort_wr_count", 64'(wr_cnt - wr0), 64'd5);
        chk("t4_abort_no_done", 64'(done_cnt - dn0), 64'd0);
        chk("t4_abort_keeps_width", 64'(width_o), 64'd4);
        do_start(2, 2);
        send(5, 2, 2, 0, 4, 1'b0, -1);
        cycles(2);
        chk("t4_restart_done", 64'(done_cnt - dn0), 64'd1);

        // Test 5: start mid-frame is rejected and the frame keeps its 2x3 geometry
        dn0 = done_cnt;
        do_start(2, 3);
        send(6, 2, 3, 0, 6, 1'b0, 2);
        cycles(2);
        chk("t5_width_kept", 64'(width_o), 64'd2);
        chk("t5_height_kept", 64'(height_o), 64'd3);
        chk("t5_done_count", 64'(done_cnt - dn0), 64'd1);

        // Test 6: asynchronous reset mid-frame
        do_start(4, 2);
        send(7, 4, 2, 0, 3, 1'b0, -1);
        @(negedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_outputs", {wr_en, busy, s_ready, frame_done, cfg_err, wr_row, wr_col, wr_r, wr_g, wr_b},
            64'd0);
        chk("t6_rst_width", 64'(width_o), 64'd0);
        chk("t6_rst_height", 64'(height_o), 64'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        cycles(2);
        chk("t6_post_s_ready", 64'(s_ready), 64'd0);
        chk("t6_post_busy", 64'(busy), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
